// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, note codes,
// note frequencies, ROM entry layout and the volume amplitude step.
package melody_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int NOTE_W    = 4;
    localparam int DUR_W     = 2;
    localparam int ENTRY_W   = NOTE_W + DUR_W;
    localparam int ROM_DEPTH = 32;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rom_entry_t;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_D5   = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_E5   = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_F5   = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_G5   = 4'd12;

    localparam int FREQ_C4 = 262;
    localparam int FREQ_D4 = 294;
    localparam int FREQ_E4 = 330;
    localparam int FREQ_F4 = 349;
    localparam int FREQ_G4 = 392;
    localparam int FREQ_A4 = 440;
    localparam int FREQ_B4 = 494;
    localparam int FREQ_C5 = 523;
    localparam int FREQ_D5 = 587;
    localparam int FREQ_E5 = 659;
    localparam int FREQ_F5 = 698;
    localparam int FREQ_G5 = 784;

    localparam logic [15:0] AMP_STEP = 16'h1000;

    // Codes 13..15 are unused pitches and behave exactly like a rest.
    function automatic logic is_tone(input logic [NOTE_W-1:0] n);
        return (n != NOTE_REST) && (n <= NOTE_G5);
    endfunction

    function automatic int note_freq(input logic [NOTE_W-1:0] n);
        case (n)
            NOTE_C4: return FREQ_C4;
            NOTE_D4: return FREQ_D4;
            NOTE_E4: return FREQ_E4;
            NOTE_F4: return FREQ_F4;
            NOTE_G4: return FREQ_G4;
            NOTE_A4: return FREQ_A4;
            NOTE_B4: return FREQ_B4;
            NOTE_C5: return FREQ_C5;
            NOTE_D5: return FREQ_D5;
            NOTE_E5: return FREQ_E5;
            NOTE_F5: return FREQ_F5;
            NOTE_G5: return FREQ_G5;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/melody_player_if.sv
// Control pulses in, tone-generator drive and status out, for melody_player.
interface melody_player_if;
    logic        play_toggle;
    logic        stop;
    logic        loop_en;
    logic        vol_up;
    logic        vol_down;
    logic [19:0] note_div;
    logic [31:0] vol_data;
    logic        playing;
    logic [4:0]  song_idx;
    logic [2:0]  vol_level;

    modport master (
        output play_toggle, stop, loop_en, vol_up, vol_down,
        input  note_div, vol_data, playing, song_idx, vol_level
    );

    modport slave (
        input  play_toggle, stop, loop_en, vol_up, vol_down,
        output note_div, vol_data, playing, song_idx, vol_level
    );
endinterface

// File: rtl/melody_rom.sv
// Fixed 32-entry song table, combinational lookup of {note, dur} by index.
module melody_rom
    import melody_pkg::*;
(
    input  logic [4:0]  idx,
    output rom_entry_t  entry
);

    always_comb begin
        entry = '{note: NOTE_REST, dur: 2'd0};
        case (idx)
            5'd0:  entry = '{note: NOTE_C4,   dur: 2'd0};
            5'd1:  entry = '{note: NOTE_REST, dur: 2'd1};
            5'd2:  entry = '{note: NOTE_A4,   dur: 2'd3};
            5'd3:  entry = '{note: NOTE_E4,   dur: 2'd0};
            5'd4:  entry = '{note: NOTE_E4,   dur: 2'd0};
            5'd5:  entry = '{note: NOTE_F4,   dur: 2'd0};
            5'd6:  entry = '{note: NOTE_G4,   dur: 2'd0};
            5'd7:  entry = '{note: NOTE_G4,   dur: 2'd0};
            5'd8:  entry = '{note: NOTE_F4,   dur: 2'd0};
            5'd9:  entry = '{note: NOTE_E4,   dur: 2'd0};
            5'd10: entry = '{note: NOTE_D4,   dur: 2'd0};
            5'd11: entry = '{note: NOTE_C4,   dur: 2'd0};
            5'd12: entry = '{note: NOTE_C4,   dur: 2'd0};
            5'd13: entry = '{note: NOTE_D4,   dur: 2'd0};
            5'd14: entry = '{note: NOTE_E4,   dur: 2'd0};
            5'd15: entry = '{note: NOTE_E4,   dur: 2'd1};
            5'd16: entry = '{note: NOTE_D4,   dur: 2'd0};
            5'd17: entry = '{note: NOTE_D4,   dur: 2'd1};
            5'd18: entry = '{note: 4'd14,     dur: 2'd0};
            5'd19: entry = '{note: NOTE_C5,   dur: 2'd0};
            5'd20: entry = '{note: NOTE_D5,   dur: 2'd0};
            5'd21: entry = '{note: NOTE_E5,   dur: 2'd1};
            5'd22: entry = '{note: NOTE_F5,   dur: 2'd0};
            5'd23: entry = '{note: NOTE_G5,   dur: 2'd2};
            5'd24: entry = '{note: NOTE_REST, dur: 2'd0};
            5'd25: entry = '{note: NOTE_G5,   dur: 2'd0};
            5'd26: entry = '{note: NOTE_E5,   dur: 2'd0};
            5'd27: entry = '{note: NOTE_B4,   dur: 2'd0};
            5'd28: entry = '{note: 4'd15,     dur: 2'd0};
            5'd29: entry = '{note: 4'd13,     dur: 2'd1};
            5'd30: entry = '{note: NOTE_G4,   dur: 2'd1};
            5'd31: entry = '{note: NOTE_C4,   dur: 2'd3};
            default: entry = '{note: NOTE_REST, dur: 2'd0};
        endcase
    end

endmodule

// File: rtl/melody_player.sv
// Song sequencer feeding buzzer_control; note_div/vol_data lag state/index by one clk.
// Define MELODY_GAP_EN to silence the last BEAT_CYC/8 cycles of each sounding note.
module melody_player
    import melody_pkg::*;
#(
    parameter int CLK_HZ   = 40_000_000,
    parameter int BEAT_CYC = 5_000_000
) (
    input  logic           clk,
    input  logic           rst,
    melody_player_if.slave bus
);

    localparam int              CW       = $clog2(BEAT_CYC);
    localparam logic [CW-1:0]   CYC_LAST = CW'(BEAT_CYC - 1);
`ifdef MELODY_GAP_EN
    localparam logic [CW-1:0]   GAP_START = CW'(BEAT_CYC - BEAT_CYC / 8);
`endif

    state_t        state, state_nx;
    logic [4:0]    idx, idx_nx;
    logic [CW-1:0] cyc, cyc_nx;
    logic [1:0]    beat, beat_nx;
    logic [2:0]    vol, vol_nx;
    logic [19:0]   note_div_q, note_div_nx;
    logic [31:0]   vol_data_q, vol_data_nx;
    logic          playing_q;
    logic          entry_end;
    logic          sounding;
    logic [15:0]   amp;
    rom_entry_t    entry;
    logic [19:0]   div_tab [16];

    melody_rom u_rom (
        .idx   (idx),
        .entry (entry)
    );

    // Constant-folded divider table; rests map to 0 and are never selected.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            if (note_freq(4'(i)) == 0)
                div_tab[i] = '0;
            else
                div_tab[i] = 20'(CLK_HZ / (2 * note_freq(4'(i))) - 1);
        end
    end

    assign entry_end = (state == PLAY) && (cyc == CYC_LAST) && (beat == entry.dur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cyc_nx   = cyc;
        beat_nx  = beat;
        if (state == PLAY) begin
            if (cyc == CYC_LAST) begin
                cyc_nx = '0;
                if (beat == entry.dur) begin
                    beat_nx = '0;
                    idx_nx  = idx + 5'd1;
                end else begin
                    beat_nx = beat + 2'd1;
                end
            end else begin
                cyc_nx = cyc + CW'(1);
            end
        end
        case (state)
            IDLE: begin
                if (bus.play_toggle) begin
                    state_nx = PLAY;
                    idx_nx   = '0;
                    cyc_nx   = '0;
                    beat_nx  = '0;
                end
            end
            PLAY: begin
                // Song end without looping takes priority over a pause request.
                if (entry_end && (idx == 5'd31) && !bus.loop_en) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (bus.play_toggle) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.play_toggle) state_nx = PLAY;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.stop) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cyc_nx   = '0;
            beat_nx  = '0;
        end
    end

    always_comb begin
        vol_nx = vol;
        if (bus.vol_up && !bus.vol_down && (vol != 3'd7))
            vol_nx = vol + 3'd1;
        else if (bus.vol_down && !bus.vol_up && (vol != 3'd0))
            vol_nx = vol - 3'd1;
    end

    assign amp = AMP_STEP * {13'd0, vol};

    always_comb begin
        sounding = (state == PLAY) && is_tone(entry.note);
`ifdef MELODY_GAP_EN
        if ((beat == entry.dur) && (cyc >= GAP_START))
            sounding = 1'b0;
`endif
        note_div_nx = note_div_q;
        if ((state == PLAY) && is_tone(entry.note))
            note_div_nx = div_tab[entry.note];
        vol_data_nx = sounding ? {amp, 16'(-amp)} : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            cyc        <= '0;
            beat       <= '0;
            vol        <= 3'd4;
            note_div_q <= '0;
            vol_data_q <= '0;
            playing_q  <= 1'b0;
        end else begin
            idx        <= idx_nx;
            cyc        <= cyc_nx;
            beat       <= beat_nx;
            vol        <= vol_nx;
            note_div_q <= note_div_nx;
            vol_data_q <= vol_data_nx;
            playing_q  <= (state_nx == PLAY);
        end
    end

    assign bus.note_div  = note_div_q;
    assign bus.vol_data  = vol_data_q;
    assign bus.playing   = playing_q;
    assign bus.song_idx  = idx;
    assign bus.vol_level = vol;

endmodule

// File: tb/tb_melody_player.sv
// Randomized scoreboard bench for melody_player against a beat-time song model.
module tb_melody_player;

    localparam int CLK_HZ = 40_000_000;
    localparam int BEAT   = 16;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;

    typedef struct packed {
        logic [19:0] nd;
        logic [31:0] vd;
        logic        pl;
        logic [4:0]  si;
        logic [2:0]  vl;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    melody_player_if bus ();

    melody_player #(
        .CLK_HZ   (CLK_HZ),
        .BEAT_CYC (BEAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passed = 0;

    int note_tab [32];
    int dur_tab  [32];
    int freq     [16];

    int          m_mode, m_idx, m_t, m_vol;
    logic [19:0] m_nd;
    logic [31:0] m_vd;

    initial begin
        note_tab = '{1, 0, 6, 3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3,
                     2, 2, 14, 8, 9, 10, 11, 12, 0, 12, 10, 7, 15, 13, 5, 1};
        dur_tab  = '{0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 1, 3};
        freq     = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 0, 0, 0};
    end

    function automatic obs_t model_obs();
        obs_t o;
        o.nd = m_nd;
        o.vd = m_vd;
        o.pl = (m_mode == M_PLAY);
        o.si = 5'(m_idx);
        o.vl = 3'(m_vol);
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_idx  = 0;
        m_t    = 0;
        m_vol  = 4;
        m_nd   = '0;
        m_vd   = '0;
    endtask

    // One clock edge of the song: outputs from the pre-edge position, then advance.
    task automatic model_edge(input bit pt, input bit st, input bit up, input bit dn, input bit lp);
        int  n;
        int  len;
        int  a;
        int  na;
        bit  tone;
        bit  quiet;
        n    = note_tab[m_idx];
        len  = (dur_tab[m_idx] + 1) * BEAT;
        tone = (n >= 1) && (n <= 12);
        a    = m_vol * 4096;
        na   = -a;
        if (m_mode == M_PLAY && tone) begin
            m_nd  = 20'(CLK_HZ / (2 * freq[n]) - 1);
            quiet = 1'b0;
`ifdef MELODY_GAP_EN
            quiet = (m_t >= len - BEAT / 8);
`endif
            m_vd = quiet ? 32'd0 : {a[15:0], na[15:0]};
        end else begin
            m_vd = 32'd0;
        end

        if (st) begin
            m_mode = M_IDLE;
            m_idx  = 0;
            m_t    = 0;
        end else if (m_mode == M_IDLE) begin
            if (pt) begin
                m_mode = M_PLAY;
                m_idx  = 0;
                m_t    = 0;
            end
        end else if (m_mode == M_PAUSE) begin
            if (pt) m_mode = M_PLAY;
        end else begin
            m_t++;
            if (m_t == len) begin
                m_t = 0;
                if (m_idx == 31) begin
                    m_idx = 0;
                    if (!lp) m_mode = M_IDLE;
                end else begin
                    m_idx++;
                end
            end
            if (pt && m_mode == M_PLAY) m_mode = M_PAUSE;
        end

        if (up && !dn && m_vol < 7) m_vol++;
        else if (dn && !up && m_vol > 0) m_vol--;
    endtask

    task automatic step(input bit pt, input bit st, input bit up, input bit dn, input string tag);
        @(negedge clk);
        rst             = 1'b0;
        bus.play_toggle = pt;
        bus.stop        = st;
        bus.vol_up      = up;
        bus.vol_down    = dn;
        model_edge(pt, st, up, dn, bus.loop_en);
        exp_q.push_back(model_obs());
        tag_q.push_back(tag);
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge clk);
        rst             = 1'b1;
        bus.play_toggle = 1'b0;
        bus.stop        = 1'b0;
        bus.vol_up      = 1'b0;
        bus.vol_down    = 1'b0;
        model_reset();
        exp_q.push_back(model_obs());
        tag_q.push_back(tag);
    endtask

    obs_t  got;
    obs_t  want;
    string wtag;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                wtag = tag_q.pop_front();
                got  = '{nd: bus.note_div, vd: bus.vol_data, pl: bus.playing,
                         si: bus.song_idx, vl: bus.vol_level};
                checks++;
                if (got === want) begin
                    passed++;
                end else begin
                    $display("FAIL %s @%0t: got nd=%0d vd=%h pl=%0b idx=%0d vol=%0d, expected nd=%0d vd=%h pl=%0b idx=%0d vol=%0d",
                             wtag, $time, got.nd, got.vd, got.pl, got.si, got.vl,
                             want.nd, want.vd, want.pl, want.si, want.vl);
                end
            end
        end
    end

    initial begin
        int guard;
        bus.play_toggle = 1'b0;
        bus.stop        = 1'b0;
        bus.loop_en     = 1'b0;
        bus.vol_up      = 1'b0;
        bus.vol_down    = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) reset_cycle("reset");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "idle");

        step(1, 0, 0, 0, "play_start");
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, "entry0");
        for (int i = 0; i < 32; i++) step(0, 0, 0, 0, "entry1_rest");
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, "entry2");
        step(1, 0, 0, 0, "pause");
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, "paused");
        step(1, 0, 0, 0, "resume");
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, "entry2_tail");

        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, "vol_up_sat");
        step(0, 0, 1, 1, "vol_both");
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, "vol_down_sat");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "vol_restore");

        guard = 0;
        while (m_mode != M_IDLE && guard < 3000) begin
            step(0, 0, 0, 0, "run_to_end");
            guard++;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "ended_idle");

        bus.loop_en = 1'b1;
        step(1, 0, 0, 0, "loop_start");
        for (int i = 0; i < 800; i++) step(0, 0, 0, 0, "loop_wrap");
        step(1, 1, 0, 0, "stop_and_toggle");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "stopped");

        step(1, 0, 0, 0, "rand_start");
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                reset_cycle("mid_reset");
            end else begin
                if ($urandom_range(0, 299) == 0) bus.loop_en = ~bus.loop_en;
                step($urandom_range(0, 59) == 0, $urandom_range(0, 599) == 0,
                     $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, "random");
            end
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
